// File: rtl/si_seq_pkg.sv
// Shared encodings and elaboration helpers for the reset/run-window sequencer.
package si_seq_pkg;

  localparam logic [1:0] HOLD    = 2'd0;
  localparam logic [1:0] RELEASE = 2'd1;
  localparam logic [1:0] RUN     = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  function automatic int rel_offset(input int idx, input int stagger);
    return idx * stagger;
  endfunction

endpackage

// File: rtl/si_seq_counter.sv
// Up-counter with synchronous clear, enable and optional saturation at all-ones.
module si_seq_counter #(
  parameter int CNT_W = 32,
  parameter bit SAT   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] q
);

  logic [CNT_W-1:0] q_r;
  logic             at_max_s;

  assign at_max_s = SAT && (&q_r);

  // Count register; clear has priority over counting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      q_r <= {CNT_W{1'b0}};
    end else if (en && !at_max_s) begin
      q_r <= q_r + CNT_W'(1);
    end
  end

  assign q = q_r;

endmodule

// File: rtl/si_reset_sequencer.sv
// Staggered reset release followed by a bounded run window, with cold/warm restart.
module si_reset_sequencer
  import si_seq_pkg::*;
#(
  parameter int NUM_CH    = 3,
  parameter int COLD_HOLD = 10,
  parameter int WARM_HOLD = 4,
  parameter int STAGGER   = 2,
  parameter int RUN_LIMIT = 1000,
  parameter int CNT_W     = 32
) (
  input  logic              SI_ClkIn,
  input  logic              SI_Reset,
  input  logic              cold_req,
  input  logic              warm_req,
  output logic [NUM_CH-1:0] rst_out_n,
  output logic              cold_rst_n,
  output logic              busy,
  output logic [CNT_W-1:0]  run_cnt,
  output logic              stop,
  output logic              done
);

  localparam logic [CNT_W-1:0] COLD_M1    = CNT_W'(COLD_HOLD - 1);
  localparam logic [CNT_W-1:0] WARM_M1    = CNT_W'(WARM_HOLD - 1);
  localparam logic [CNT_W-1:0] LAST_OFF   = CNT_W'(rel_offset(NUM_CH - 1, STAGGER));
  localparam int               RUN_TERM_I = (RUN_LIMIT == 0) ? 0 : RUN_LIMIT - 1;
  localparam logic [CNT_W-1:0] RUN_TERM   = CNT_W'(RUN_TERM_I);
  localparam bit               RUN_BOUNDED = (RUN_LIMIT != 0);

  logic [1:0]        state_r;
  logic              cold_r;
  logic [NUM_CH-1:0] rst_out_n_r;
  logic              cold_rst_n_r;
  logic              busy_r;
  logic              stop_r;
  logic              done_r;

  logic [CNT_W-1:0]  cnt_s;
  logic [CNT_W-1:0]  run_cnt_s;
  logic [NUM_CH-1:0] rel_hit_s;
  logic              req_any_s;
  logic              hold_end_s;
  logic              last_rel_s;
  logic              run_term_s;
  logic              cnt_clr_s;
  logic              cnt_en_s;
  logic              run_clr_s;
  logic              run_en_s;

  si_seq_counter #(.CNT_W(CNT_W), .SAT(1'b0)) u_hold_cnt (
    .clk (SI_ClkIn),
    .rst (SI_Reset),
    .clr (cnt_clr_s),
    .en  (cnt_en_s),
    .q   (cnt_s)
  );

  si_seq_counter #(.CNT_W(CNT_W), .SAT(1'b1)) u_run_cnt (
    .clk (SI_ClkIn),
    .rst (SI_Reset),
    .clr (run_clr_s),
    .en  (run_en_s),
    .q   (run_cnt_s)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_rel
      localparam logic [CNT_W-1:0] OFF = CNT_W'(rel_offset(gi, STAGGER));
      assign rel_hit_s[gi] = (cnt_s == OFF);
    end
  endgenerate

  // Counter control and end-of-phase decodes
  always_comb begin
    req_any_s  = cold_req | warm_req;
    hold_end_s = (cnt_s == (cold_r ? COLD_M1 : WARM_M1));
    last_rel_s = (cnt_s == LAST_OFF);
    run_term_s = RUN_BOUNDED && (run_cnt_s == RUN_TERM);
    cnt_clr_s  = 1'b0;
    cnt_en_s   = 1'b0;
    run_clr_s  = 1'b0;
    run_en_s   = 1'b0;
    case (state_r)
      HOLD: begin
        if (cold_req || hold_end_s) begin
          cnt_clr_s = 1'b1;
        end else begin
          cnt_en_s = 1'b1;
        end
      end
      RELEASE: begin
        if (req_any_s || last_rel_s) begin
          cnt_clr_s = 1'b1;
          run_clr_s = req_any_s;
        end else begin
          cnt_en_s = 1'b1;
        end
      end
      RUN: begin
        if (req_any_s) begin
          cnt_clr_s = 1'b1;
          run_clr_s = 1'b1;
        end else begin
          run_en_s = !run_term_s;
        end
      end
      DONE: begin
        if (req_any_s) begin
          cnt_clr_s = 1'b1;
          run_clr_s = 1'b1;
        end else begin
          cnt_en_s = 1'b0;
        end
      end
      default: begin
        cnt_clr_s = 1'b1;
        run_clr_s = 1'b1;
      end
    endcase
  end

  // Sequencer state and registered outputs; a request outranks a pending stop
  always_ff @(posedge SI_ClkIn or posedge SI_Reset) begin
    if (SI_Reset) begin
      state_r      <= HOLD;
      cold_r       <= 1'b1;
      rst_out_n_r  <= {NUM_CH{1'b0}};
      cold_rst_n_r <= 1'b0;
      busy_r       <= 1'b1;
      stop_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      stop_r <= 1'b0;
      case (state_r)
        HOLD: begin
          if (cold_req) begin
            cold_r       <= 1'b1;
            cold_rst_n_r <= 1'b0;
          end else if (hold_end_s) begin
            state_r      <= RELEASE;
            cold_rst_n_r <= 1'b1;
          end
        end
        RELEASE, RUN, DONE: begin
          if (req_any_s) begin
            state_r     <= HOLD;
            rst_out_n_r <= {NUM_CH{1'b0}};
            done_r      <= 1'b0;
            busy_r      <= 1'b1;
            cold_r      <= cold_req;
            if (cold_req) begin
              cold_rst_n_r <= 1'b0;
            end
          end else if (state_r == RELEASE) begin
            rst_out_n_r <= rst_out_n_r | rel_hit_s;
            if (last_rel_s) begin
              state_r <= RUN;
              busy_r  <= 1'b0;
            end
          end else if ((state_r == RUN) && run_term_s) begin
            state_r <= DONE;
            stop_r  <= 1'b1;
            done_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= HOLD;
        end
      endcase
    end
  end

  assign rst_out_n  = rst_out_n_r;
  assign cold_rst_n = cold_rst_n_r;
  assign busy       = busy_r;
  assign run_cnt    = run_cnt_s;
  assign stop       = stop_r;
  assign done       = done_r;

endmodule

// File: tb/tb_si_reset_sequencer.sv
// Self-checking bench: timed expectation tables fed through a scoreboard queue.
module tb_si_reset_sequencer;

  typedef struct {
    int         rel;
    logic       cold;
    logic       warm;
    logic [2:0] rst;
    logic       cold_n;
    logic       busy;
    logic       done;
    logic       stop;
    int         run;
  } vec_t;

  logic clk = 1'b0;
  logic SI_Reset, cold_req, warm_req, side_cold, side_warm;

  logic [2:0]  rst_out_n;
  logic        cold_rst_n, busy, stop, done;
  logic [31:0] run_cnt;

  logic [3:0]  s0_rst_out_n;
  logic        s0_cold_rst_n, s0_busy, s0_stop, s0_done;
  logic [31:0] s0_run_cnt;

  logic [2:0]  ul_rst_out_n;
  logic        ul_cold_rst_n, ul_busy, ul_stop, ul_done;
  logic [7:0]  ul_run_cnt;

  int checks = 0;
  int failures = 0;
  int edge_n = 0;
  int stop_cnt = 0;
  int ul_stop_cnt = 0;
  vec_t tbl[$];
  vec_t sb[$];

  always #5 clk = ~clk;

  si_reset_sequencer dut (
    .SI_ClkIn(clk), .SI_Reset(SI_Reset), .cold_req(cold_req), .warm_req(warm_req),
    .rst_out_n(rst_out_n), .cold_rst_n(cold_rst_n), .busy(busy),
    .run_cnt(run_cnt), .stop(stop), .done(done)
  );

  si_reset_sequencer #(.NUM_CH(4), .STAGGER(0)) dut_s0 (
    .SI_ClkIn(clk), .SI_Reset(SI_Reset), .cold_req(side_cold), .warm_req(side_warm),
    .rst_out_n(s0_rst_out_n), .cold_rst_n(s0_cold_rst_n), .busy(s0_busy),
    .run_cnt(s0_run_cnt), .stop(s0_stop), .done(s0_done)
  );

  si_reset_sequencer #(.RUN_LIMIT(0), .CNT_W(8)) dut_ul (
    .SI_ClkIn(clk), .SI_Reset(SI_Reset), .cold_req(side_cold), .warm_req(side_warm),
    .rst_out_n(ul_rst_out_n), .cold_rst_n(ul_cold_rst_n), .busy(ul_busy),
    .run_cnt(ul_run_cnt), .stop(ul_stop), .done(ul_done)
  );

  function automatic vec_t mk(input int rel, input logic c, input logic w, input logic [2:0] r,
                              input logic cn, input logic b, input logic d, input logic s,
                              input int rc);
    vec_t v;
    v.rel = rel; v.cold = c; v.warm = w; v.rst = r; v.cold_n = cn;
    v.busy = b; v.done = d; v.stop = s; v.run = rc;
    return v;
  endfunction

  task automatic cmp(input string nm, input int e, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s edge=%0d actual=%0h expected=%0h", nm, e, act, exp);
    end
  endtask

  // Cold sequence relative to the edge that starts the hold (edge 0)
  task automatic add_cold(input int off);
    tbl.push_back(mk(9 + off, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 0));
    tbl.push_back(mk(10 + off, 1'b0, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 0));
    tbl.push_back(mk(11 + off, 1'b0, 1'b0, 3'b001, 1'b1, 1'b1, 1'b0, 1'b0, 0));
    tbl.push_back(mk(12 + off, 1'b0, 1'b0, 3'b001, 1'b1, 1'b1, 1'b0, 1'b0, 0));
    tbl.push_back(mk(13 + off, 1'b0, 1'b0, 3'b011, 1'b1, 1'b1, 1'b0, 1'b0, 0));
    tbl.push_back(mk(14 + off, 1'b0, 1'b0, 3'b011, 1'b1, 1'b1, 1'b0, 1'b0, 0));
    tbl.push_back(mk(15 + off, 1'b0, 1'b0, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 0));
    tbl.push_back(mk(16 + off, 1'b0, 1'b0, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 1));
  endtask

  task automatic step();
    vec_t v;
    @(posedge clk);
    #1;
    edge_n++;
    if (stop) stop_cnt++;
    if (ul_stop) ul_stop_cnt++;
    while (sb.size() > 0 && sb[0].rel <= edge_n) begin
      v = sb.pop_front();
      cmp("edge", v.rel, 32'(edge_n), 32'(v.rel));
      cmp("rst_out_n", v.rel, 32'(rst_out_n), 32'(v.rst));
      cmp("cold_rst_n", v.rel, 32'(cold_rst_n), 32'(v.cold_n));
      cmp("busy", v.rel, 32'(busy), 32'(v.busy));
      cmp("done", v.rel, 32'(done), 32'(v.done));
      cmp("stop", v.rel, 32'(stop), 32'(v.stop));
      cmp("run_cnt", v.rel, run_cnt, 32'(v.run));
    end
  endtask

  task automatic run_to(input int n);
    while (edge_n < n) step();
  endtask

  task automatic apply(input int base, input int lo, input int hi);
    vec_t v;
    for (int i = lo; i <= hi; i++) begin
      v = tbl[i];
      run_to(base + v.rel - 1);
      cold_req = v.cold;
      warm_req = v.warm;
      v.rel = base + v.rel;
      sb.push_back(v);
      step();
      cold_req = 1'b0;
      warm_req = 1'b0;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    cmp({tag, "_rst_out_n"}, edge_n, 32'(rst_out_n), 32'd0);
    cmp({tag, "_cold_rst_n"}, edge_n, 32'(cold_rst_n), 32'd0);
    cmp({tag, "_busy"}, edge_n, 32'(busy), 32'd1);
    cmp({tag, "_done"}, edge_n, 32'(done), 32'd0);
    cmp({tag, "_stop"}, edge_n, 32'(stop), 32'd0);
    cmp({tag, "_run_cnt"}, edge_n, run_cnt, 32'd0);
  endtask

  initial begin
    int r3;
    int w;
    int x;
    SI_Reset = 1'b1; cold_req = 1'b0; warm_req = 1'b0;
    side_cold = 1'b0; side_warm = 1'b0;
    #12;
    check_reset_vals("por");
    SI_Reset = 1'b0;
    edge_n = 0;

    // Power-on cold sequence and full run window
    tbl.delete();
    add_cold(0);
    tbl.push_back(mk(1014, 1'b0, 1'b0, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 999));
    tbl.push_back(mk(1015, 1'b0, 1'b0, 3'b111, 1'b1, 1'b0, 1'b1, 1'b1, 999));
    tbl.push_back(mk(1016, 1'b0, 1'b0, 3'b111, 1'b1, 1'b0, 1'b1, 1'b0, 999));
    tbl.push_back(mk(1020, 1'b0, 1'b0, 3'b111, 1'b1, 1'b0, 1'b1, 1'b0, 999));
    apply(0, 0, 1);
    cmp("s0_rst_before", edge_n, 32'(s0_rst_out_n), 32'h0);
    apply(0, 2, 2);
    cmp("s0_rst_together", edge_n, 32'(s0_rst_out_n), 32'hF);
    apply(0, 3, 7);
    run_to(300);
    cmp("ul_run_sat", edge_n, 32'(ul_run_cnt), 32'hFF);
    apply(0, 8, 11);
    cmp("stop_pulses", edge_n, 32'(stop_cnt), 32'd1);
    cmp("ul_run_hold", edge_n, 32'(ul_run_cnt), 32'hFF);
    cmp("ul_stop_none", edge_n, 32'(ul_stop_cnt), 32'd0);
    cmp("ul_done", edge_n, 32'(ul_done), 32'd0);

    // Cold and warm together in DONE: cold wins
    r3 = edge_n + 1;
    tbl.delete();
    tbl.push_back(mk(0, 1'b1, 1'b1, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 0));
    add_cold(0);
    tbl.push_back(mk(115, 1'b0, 1'b0, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 100));
    apply(r3, 0, tbl.size() - 1);

    // Warm restart from RUN at run_cnt=100
    w = r3 + 116;
    tbl.delete();
    tbl.push_back(mk(0, 1'b0, 1'b1, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 0));
    tbl.push_back(mk(4, 1'b0, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 0));
    tbl.push_back(mk(5, 1'b0, 1'b0, 3'b001, 1'b1, 1'b1, 1'b0, 1'b0, 0));
    tbl.push_back(mk(6, 1'b0, 1'b0, 3'b001, 1'b1, 1'b1, 1'b0, 1'b0, 0));
    tbl.push_back(mk(7, 1'b0, 1'b0, 3'b011, 1'b1, 1'b1, 1'b0, 1'b0, 0));
    tbl.push_back(mk(8, 1'b0, 1'b0, 3'b011, 1'b1, 1'b1, 1'b0, 1'b0, 0));
    tbl.push_back(mk(9, 1'b0, 1'b0, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 0));
    tbl.push_back(mk(10, 1'b0, 1'b0, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 1));
    apply(w, 0, tbl.size() - 1);

    // Cold upgrade during warm hold, then request colliding with stop, then ignored warm in HOLD
    x = w + 20;
    tbl.delete();
    tbl.push_back(mk(0, 1'b0, 1'b1, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 0));
    tbl.push_back(mk(1, 1'b0, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 0));
    tbl.push_back(mk(2, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 0));
    tbl.push_back(mk(5, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 0));
    add_cold(2);
    tbl.push_back(mk(1016, 1'b0, 1'b0, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 999));
    tbl.push_back(mk(1017, 1'b0, 1'b1, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 0));
    tbl.push_back(mk(1019, 1'b0, 1'b1, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 0));
    tbl.push_back(mk(1021, 1'b0, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 0));
    tbl.push_back(mk(1022, 1'b0, 1'b0, 3'b001, 1'b1, 1'b1, 1'b0, 1'b0, 0));
    tbl.push_back(mk(1023, 1'b0, 1'b0, 3'b001, 1'b1, 1'b1, 1'b0, 1'b0, 0));
    apply(x, 0, tbl.size() - 1);
    cmp("stop_pulses_total", edge_n, 32'(stop_cnt), 32'd1);

    // Asynchronous reset mid-RELEASE, between edges, then full cold replay
    #3;
    SI_Reset = 1'b1;
    #1;
    check_reset_vals("async");
    #1;
    SI_Reset = 1'b0;
    tbl.delete();
    tbl.push_back(mk(1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 0));
    add_cold(0);
    tbl.push_back(mk(20, 1'b0, 1'b0, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 5));
    apply(edge_n, 0, tbl.size() - 1);

    cmp("sb_drained", edge_n, 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/si_reset_sequencer.md
Name: si_reset_sequencer

Overview:
Parametrised reset and run-window sequencer for the MIPSfpga system and its bench harness. It holds NUM_CH downstream reset outputs (core, debug/TRST, peripherals, ...) for a programmable number of cycles. It releases them in a staggered order, then counts a bounded run window and pulses a stop indication. It supports cold and warm re-sequencing at run time, and the same block serves both the synthesized system and simulation benches.

Parameters:
NUM_CH, 3, number of independently released active-low reset outputs (1..8)
COLD_HOLD, 10, cycles all outputs are held after SI_Reset or cold_req (>=1)
WARM_HOLD, 4, cycles all outputs are held after warm_req (>=1)
STAGGER, 2, cycles between release of channel i and channel i+1 (0 = release together)
RUN_LIMIT, 1000, run-window length in cycles; 0 = unbounded
CNT_W, 32, width of the run counter and hold/stagger counter

Ports:
SI_ClkIn  in  1  system clock, all state on rising edge
SI_Reset  in  1  asynchronous, active-high reset; forces cold sequence
cold_req  in  1  one-cycle request to restart with cold hold
warm_req  in  1  one-cycle request to restart with warm hold
rst_out_n  out  NUM_CH  per-channel active-low reset; bit 0 released first
cold_rst_n  out  1  active-low, low only during a cold hold
busy  out  1  high in HOLD or RELEASE
run_cnt  out  CNT_W  cycles spent in RUN since last release
stop  out  1  one-cycle pulse when run window expires
done  out  1  sticky, high in DONE

Behaviour:
- States: HOLD, RELEASE, RUN, DONE. A flag `cold` selects the hold length (COLD_HOLD if set, else WARM_HOLD).
- Reset values under SI_Reset:
  - state=HOLD, cold=1, cnt=0, run_cnt=0
  - rst_out_n=0, cold_rst_n=0, stop=0, done=0, busy=1
- HOLD, each edge:
  - If cnt==hold-1: state<=RELEASE, cnt<=0, cold_rst_n<=1.
  - Otherwise cnt<=cnt+1.
- RELEASE, each edge:
  - For each i with cnt==i*STAGGER: rst_out_n[i]<=1.
  - If cnt==(NUM_CH-1)*STAGGER: state<=RUN, cnt<=0, busy<=0. Otherwise cnt++.
  - Released bits stay 1 until the next HOLD.
- RUN, each edge:
  - run_cnt<=run_cnt+1.
  - If RUN_LIMIT!=0 and run_cnt==RUN_LIMIT-1: state<=DONE, stop<=1 for exactly one cycle, done<=1.
  - If RUN_LIMIT==0: run_cnt saturates at all-ones and never wraps.
- DONE: outputs stay released; run_cnt frozen; remains until a request arrives.
- Latency from SI_Reset deassertion (edge 1 = first rising edge):
  - cold_rst_n high after edge COLD_HOLD.
  - Channel i high after edge COLD_HOLD+1+i*STAGGER.
  - RUN entered on the same edge as the last channel release.
- Requests in RELEASE, RUN or DONE. On the next edge:
  - state<=HOLD, cnt<=0, rst_out_n<=0, run_cnt<=0, done<=0, busy<=1.
  - cold_req: cold<=1, cold_rst_n<=0.
  - warm_req: cold<=0, cold_rst_n unchanged (stays 1).
- Simultaneous cold_req and warm_req: cold wins.
- Requests during HOLD:
  - warm_req is ignored.
  - cold_req during a warm hold upgrades to cold: cold<=1, cold_rst_n<=0, cnt<=0 (full COLD_HOLD restarts).
  - cold_req during a cold hold restarts cnt at 0.
- Request on the same edge that stop would fire: the request wins; stop is not pulsed, done stays 0.
- SI_Reset asserted mid-operation: all outputs return to reset values immediately (asynchronous); the sequence restarts as cold.
- The stop pulse never coincides with busy=1.

Decomposition:
- Package si_seq_pkg holds the state encoding constants (HOLD=2'd0, RELEASE=2'd1, RUN=2'd2, DONE=2'd3) and a function computing release-offset = i*STAGGER at elaboration.
- One natural sub-module, si_seq_counter: CNT_W up-counter with synchronous clear, enable and optional saturation. It is instantiated twice: once for the hold/stagger counter and once for run_cnt (saturating).
- The channel release compare is a generate loop in the top module.

Test Plan:
1. Power-on with defaults: release SI_Reset before edge 1.
   - cold_rst_n rises after edge 10.
   - rst_out_n = 3'b001 after edge 11, 3'b011 after edge 13, 3'b111 after edge 15.
   - busy falls after edge 15.
   - stop pulses exactly once after edge 1015; done=1, run_cnt=999 thereafter.
2. warm_req at run_cnt=100:
   - Next edge: rst_out_n=0, cold_rst_n stays 1, run_cnt=0.
   - Channel 0 releases 5 edges later, channel 2 releases 9 edges later.
3. cold_req and warm_req together in DONE:
   - cold_rst_n=0.
   - Hold lasts 10 cycles; done clears on the next edge.
4. cold_req on the 2nd cycle of a warm hold: hold restarts, cold_rst_n goes low, channel 0 releases 11 edges after the request.
5. Parameter sweep, each run separately:
   - STAGGER=0, NUM_CH=4: all four bits rise on the same edge.
   - RUN_LIMIT=0: forced run_cnt at all-ones stays put, and stop never pulses.
6. SI_Reset pulsed asynchronously mid-RELEASE, between clock edges:
   - Outputs reach reset values without waiting for an edge.
   - A full cold sequence replays with the same timing as scenario 1.
